// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI master / SPI slave / RAM subsystem:
// command opcodes, frame geometry and the master state encoding.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_RECV  = 3'd4,
    ST_END   = 3'd5
  } master_state_t;

endpackage

// File: rtl/spi_master.sv
// Command-issuing SPI master: serialises one {op, payload} frame per accepted
// command MSB-first and, for read-data commands, captures the returned byte.
module spi_master
  import spi_ram_pkg::*;
#(
  parameter int RD_TURN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_BITS-1:0] cmd_payload,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic                 done,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data
);

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] TURN_LAST  = 4'(RD_TURN - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_BITS - 1);

  master_state_t         r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [DATA_BITS-1:0]  r_rd_shift, w_rd_shift_nxt;
  logic                  r_rd_cmd, w_rd_cmd_nxt;
  logic                  r_ss_n, w_ss_n_nxt;
  logic                  r_mosi, w_mosi_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_rd_valid, w_rd_valid_nxt;
  logic [DATA_BITS-1:0]  r_rd_data, w_rd_data_nxt;
  logic                  w_accept;

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) w_state_nxt = ST_SEL;
        else           w_state_nxt = ST_IDLE;
      end
      ST_SEL: w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (r_cnt != SHIFT_LAST) w_state_nxt = ST_SHIFT;
        else if (!r_rd_cmd)      w_state_nxt = ST_END;
        else if (RD_TURN == 0)   w_state_nxt = ST_RECV;
        else                     w_state_nxt = ST_TURN;
      end
      ST_TURN: begin
        if (r_cnt == TURN_LAST) w_state_nxt = ST_RECV;
        else                    w_state_nxt = ST_TURN;
      end
      ST_RECV: begin
        if (r_cnt == RECV_LAST) w_state_nxt = ST_END;
        else                    w_state_nxt = ST_RECV;
      end
      ST_END:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output values for the upcoming cycle, keyed on the next state
  // so that every pin comes straight from a flop.
  always_comb begin
    w_shreg_nxt    = r_shreg;
    w_rd_shift_nxt = r_rd_shift;
    w_rd_cmd_nxt   = r_rd_cmd;
    w_ss_n_nxt     = 1'b1;
    w_mosi_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_rd_valid_nxt = 1'b0;
    w_rd_data_nxt  = r_rd_data;

    if ((w_state_nxt == r_state) && (r_state != ST_IDLE)) w_cnt_nxt = r_cnt + 4'd1;
    else                                                    w_cnt_nxt = 4'd0;

    if (w_accept) begin
      w_shreg_nxt  = {cmd_op, cmd_payload};
      w_rd_cmd_nxt = (cmd_op == CMD_RD_DATA);
    end else if (w_state_nxt == ST_SHIFT) begin
      w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], 1'b0};
    end else begin
      w_shreg_nxt = r_shreg;
    end

    if (r_state == ST_RECV) w_rd_shift_nxt = {r_rd_shift[DATA_BITS-2:0], MISO};
    else                    w_rd_shift_nxt = r_rd_shift;

    case (w_state_nxt)
      ST_SEL: begin
        w_ss_n_nxt = 1'b0;
        w_mosi_nxt = cmd_op[1];
      end
      ST_SHIFT: begin
        w_ss_n_nxt = 1'b0;
        w_mosi_nxt = r_shreg[FRAME_BITS-1];
      end
      ST_TURN, ST_RECV: w_ss_n_nxt = 1'b0;
      ST_END: begin
        w_done_nxt = 1'b1;
        // The last MISO bit is sampled on the same edge that enters END.
        if (r_rd_cmd) begin
          w_rd_valid_nxt = 1'b1;
          w_rd_data_nxt  = w_rd_shift_nxt;
        end else begin
          w_rd_data_nxt  = r_rd_data;
        end
      end
      default: w_ss_n_nxt = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_shreg    <= '0;
      r_rd_shift <= '0;
      r_rd_cmd   <= 1'b0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_rd_shift <= w_rd_shift_nxt;
      r_rd_cmd   <= w_rd_cmd_nxt;
      r_ss_n     <= w_ss_n_nxt;
      r_mosi     <= w_mosi_nxt;
      r_done     <= w_done_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_data  <= w_rd_data_nxt;
    end
  end

  assign SS_n     = r_ss_n;
  assign MOSI     = r_mosi;
  assign done     = r_done;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: doc/spi_master.md
# spi_master

Command-issuing SPI master that drives the on-chip SPI slave and single-port RAM subsystem from the same clock domain. It accepts one 10-bit command word (2-bit opcode plus 8-bit payload) per valid/ready handshake and serialises it MSB-first on MOSI inside an SS_n-framed transfer. For read-data commands it also captures the 8-bit RAM word returned on MISO. It sits between a local controller (CPU bridge or test sequencer) and the SPI top-level pins.

## Interface
- RD_TURN, 2: idle cycles between the last MOSI bit of a read-data command and the first MISO sample, covering the slave rx_valid to RAM tx_valid latency.
- clk  in  1  system clock; also the SPI bit clock (one bit per cycle).
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_op  in  2  opcode: 00 write address, 01 write data, 10 read address, 11 read data.
- cmd_payload  in  8  address or data byte; don't-care content for op 11, but still shifted.
- SS_n  out  1  active-low slave select.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.
- done  out  1  one-cycle pulse when a transfer completes.
- rd_valid  out  1  one-cycle pulse, coincident with done, for op 11 only.
- rd_data  out  8  last word read; held until the next op 11 completes.

## Operation
- States: IDLE, SEL, SHIFT, TURN, RECV, END.
- IDLE: SS_n=1, MOSI=0, cmd_ready=1. On acceptance, latch {cmd_op, cmd_payload} into a 10-bit shift register and go to SEL.
- SEL (1 cycle): SS_n=0, MOSI=cmd_op[1] (read/write select bit) → SHIFT.
- SHIFT (10 cycles): MOSI = shreg[9], shift left each cycle; the 4-bit counter counts 0..9.
  - After count 9: op 11 → TURN; otherwise → END.
- TURN (RD_TURN cycles): SS_n=0, MOSI=0 → RECV.
- RECV (8 cycles): sample MISO on each rising edge into rd_shift, MSB first → END.
- END (1 cycle): SS_n=1, MOSI=0, done=1. For op 11, rd_valid=1 and rd_data is loaded from rd_shift. → IDLE.
- Commands arriving while cmd_ready=0 are not accepted. Upstream holds cmd_valid and its data until acceptance; the master never drops a held request.
- Back-to-back operation: a command presented during END is accepted in the following IDLE cycle. SS_n is therefore high for at least 2 cycles between frames.

## Timing
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, done=0, rd_valid=0, rd_data=8'h00, state=IDLE, counters 0.
- Asserting rst_n mid-frame aborts the transfer immediately: SS_n goes high asynchronously, and no done or rd_valid is produced.
- SS_n low duration: 11 cycles for ops 00/01/10; 11+RD_TURN+8 = 21 cycles (default) for op 11.
- Accept to done: 12 cycles for a write or read-address; 22 cycles for read-data at default RD_TURN.
- MOSI changes only on rising clk edges. The slave samples on the next edge.
- MISO is sampled at the rising edge of the clk that ends each RECV cycle.
- All outputs are registered; no combinational path from MISO or cmd_* to any output except cmd_ready (state decode).

## Structure
- Shared package spi_ram_pkg holds:
  - opcode localparams CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA
  - FRAME_BITS=10 and DATA_BITS=8
  - the master state enum
- The slave also imports this package.
- No sub-module inside the block.
- Verification uses a wrapper, spi_master_link, that connects spi_master to the existing SPI top for loopback tests.

## Test plan
- Reset then idle: SS_n=1, MOSI=0, cmd_ready=1, rd_data=00, done never pulses.
- op 00, payload 8'h3C: MOSI sequence 0 then 0,0,0,0,1,1,1,1,0,0; SS_n low 11 cycles; done at cycle 12.
- Loopback test: write addr 8'h10, write data 8'hA5, read addr 8'h10, read data. Required: rd_valid with rd_data=8'hA5 22 cycles after the last accept.
- Back-to-back: cmd_valid held high for 3 write commands. Required: each accepted exactly once; SS_n high ≥2 cycles between frames.
- Reset asserted at SHIFT count 5 of an op 11 transfer. Required: SS_n=1 immediately, no done or rd_valid, and the next command completes normally.
- RD_TURN=3 build: read data is still correct, and SS_n is low for 22 cycles.
